ex_mem_stage: RTL and testbench

Parametrised, handshaked EX→MEM pipeline stage. Carries the ALU result, store data, control word, destination register and exception vector from execute to memory under a valid/ready protocol with stall back-pressure, synchronous flush and NOP insertion. An optional skid slot registers `in_ready` so the back-pressure path is not combinational. A saturating bubble counter supports performance analysis.

---
 rtl/ex_mem_pkg.sv | 23 ++
 rtl/ex_mem_skid.sv | 32 +++
 rtl/ex_mem_stage.sv | 140 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: default widths,
// the "no operation" control encoding and the payload record.
package ex_mem_pkg;

  localparam int EX_MEM_ALU_W  = 32;
  localparam int EX_MEM_SW_W   = 32;
  localparam int EX_MEM_CTRL_W = 7;
  localparam int EX_MEM_REG_W  = 5;
  localparam int EX_MEM_VEC_W  = 5;
  localparam int EX_MEM_CNT_W  = 16;

  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_NOP = 7'd1;

  // One beat as seen at the default widths.
  typedef struct packed {
    logic [EX_MEM_ALU_W-1:0]  alu;
    logic [EX_MEM_SW_W-1:0]   sw;
    logic [EX_MEM_CTRL_W-1:0] control;
    logic [EX_MEM_REG_W-1:0]  regdst;
    logic [EX_MEM_VEC_W-1:0]  vector;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_skid.sv
// Single-entry payload holding register used as the skid slot.
// Load wins over unload so a same-cycle refill keeps the slot occupied;
// clear wins over both.
module ex_mem_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data_out
);

  // Slot occupancy and contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, synchronous flush,
// NOP insertion on drain and a saturating bubble counter.
// Build option: define EX_MEM_SKID_EN to add a one-entry skid slot, which
// makes in_ready a registered signal (2 beats of capacity).
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int ALU_W  = EX_MEM_ALU_W,
  parameter int SW_W   = EX_MEM_SW_W,
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(EX_MEM_CTRL_NOP),
  parameter int REG_W  = EX_MEM_REG_W,
  parameter int VEC_W  = EX_MEM_VEC_W,
  parameter int CNT_W  = EX_MEM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALU_W-1:0]  alu_in,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [REG_W-1:0]  regdst_in,
  input  logic [VEC_W-1:0]  vector_ex_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALU_W-1:0]  alu_out,
  output logic [SW_W-1:0]   sw_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [REG_W-1:0]  regdst_out,
  output logic [VEC_W-1:0]  vector_ex_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Control travels separately from the data fields because drain rewrites
  // only the control word while the data fields hold.
  localparam int D_W = ALU_W + SW_W + REG_W + VEC_W;

  logic              valid_q;
  logic [D_W-1:0]    data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  bubble_q;

  logic [D_W-1:0]    in_data;
  logic              push;
  logic              pop;
  logic              main_load;
  logic [D_W-1:0]    src_data;
  logic [CTRL_W-1:0] src_ctrl;

  assign in_data = {alu_in, sw_in, regdst_in, vector_ex_in};
  assign push    = in_valid & in_ready;
  assign pop     = valid_q & out_ready;

`ifdef EX_MEM_SKID_EN
  logic                  skid_valid;
  logic                  skid_load;
  logic                  skid_unload;
  logic [D_W+CTRL_W-1:0] skid_pay;

  assign in_ready = ~skid_valid;

  // A new beat parks in the slot when the main register cannot take it:
  // it is stalled, or it is being refilled from the slot this cycle.
  assign skid_load   = push & valid_q & (~out_ready | skid_valid);
  assign skid_unload = pop & skid_valid;

  ex_mem_skid #(
    .W (D_W + CTRL_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (skid_load),
    .unload   (skid_unload),
    .data_in  ({in_data, control_in}),
    .valid    (skid_valid),
    .data_out (skid_pay)
  );

  // Main register source: the older skid beat goes first to keep order.
  always_comb begin
    main_load = 1'b0;
    src_data  = in_data;
    src_ctrl  = control_in;
    if (pop && skid_valid) begin
      main_load = 1'b1;
      src_data  = skid_pay[D_W+CTRL_W-1:CTRL_W];
      src_ctrl  = skid_pay[CTRL_W-1:0];
    end else if (push && !(valid_q && !out_ready)) begin
      main_load = 1'b1;
    end
  end
`else
  assign in_ready = ~valid_q | out_ready;

  // Main register source: only the input port without a skid slot.
  always_comb begin
    main_load = push;
    src_data  = in_data;
    src_ctrl  = control_in;
  end
`endif

  // Main register: flush, load, drain-to-NOP, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_NOP;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_NOP;
    end else if (main_load) begin
      valid_q <= 1'b1;
      data_q  <= src_data;
      ctrl_q  <= src_ctrl;
    end else if (pop) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end
  end

  // Bubble counter: saturating, survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (out_ready && !valid_q && !(&bubble_q)) begin
      bubble_q <= bubble_q + 1'b1;
    end
  end

  assign out_valid   = valid_q;
  assign control_out = ctrl_q;
  assign {alu_out, sw_out, regdst_out, vector_ex_out} = data_q;
  assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage. Accepted beats are queued from a
// bench-side occupancy model and compared when the stage presents them.
// A second instance with a 4-bit bubble counter shares all stimulus.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_in;
  logic [31:0] sw_in;
  logic [6:0]  control_in;
  logic [4:0]  regdst_in;
  logic [4:0]  vector_ex_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic [31:0] sw_out;
  logic [6:0]  control_out;
  logic [4:0]  regdst_out;
  logic [4:0]  vector_ex_out;
  logic [15:0] bubble_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] alu4;
  logic [31:0] sw4;
  logic [6:0]  ctrl4;
  logic [4:0]  regdst4;
  logic [4:0]  vec4;
  logic [3:0]  bubble4;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_in(alu_in), .sw_in(sw_in), .control_in(control_in),
    .regdst_in(regdst_in), .vector_ex_in(vector_ex_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .sw_out(sw_out), .control_out(control_out),
    .regdst_out(regdst_out), .vector_ex_out(vector_ex_out),
    .bubble_cnt(bubble_cnt)
  );

  ex_mem_stage #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .alu_in(alu_in), .sw_in(sw_in), .control_in(control_in),
    .regdst_in(regdst_in), .vector_ex_in(vector_ex_in),
    .out_valid(out_valid4), .out_ready(out_ready),
    .alu_out(alu4), .sw_out(sw4), .control_out(ctrl4),
    .regdst_out(regdst4), .vector_ex_out(vec4),
    .bubble_cnt(bubble4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_payload_t q[$];
  ex_mem_payload_t cur;
  logic [15:0]     cnt_m;
  logic [3:0]      cnt4_m;
  logic            flushed;
  logic            accepted;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_mem_payload_t mk(input logic [31:0] a);
    ex_mem_payload_t p;
    p.alu     = a;
    p.sw      = a ^ 32'hA5A5_0000;
    p.control = 7'h40 | {1'b0, a[5:0]};
    p.regdst  = a[4:0] ^ 5'h15;
    p.vector  = a[7:3];
    return p;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a);
    cur          = mk(a);
    in_valid     = v;
    alu_in       = cur.alu;
    sw_in        = cur.sw;
    control_in   = cur.control;
    regdst_in    = cur.regdst;
    vector_ex_in = cur.vector;
  endtask

  // One clock: check outputs at the falling edge, advance the model at
  // the rising edge, return 1 time unit later for the next drive.
  task automatic step();
    logic exp_ov, exp_ir, push, pop;
    @(negedge clk);
    exp_ov = (q.size() != 0);
`ifdef EX_MEM_SKID_EN
    exp_ir = (q.size() < 2);
`else
    exp_ir = !exp_ov || out_ready;
`endif
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("out_valid4", out_valid4, exp_ov);
    check_eq("in_ready", in_ready, exp_ir);
    check_eq("bubble_cnt", bubble_cnt, cnt_m);
    check_eq("bubble_cnt4", bubble4, cnt4_m);
    if (exp_ov) begin
      check_eq("alu_out", alu_out, q[0].alu);
      check_eq("sw_out", sw_out, q[0].sw);
      check_eq("control_out", control_out, q[0].control);
      check_eq("regdst_out", regdst_out, q[0].regdst);
      check_eq("vector_ex_out", vector_ex_out, q[0].vector);
      check_eq("payload4", {alu4, ctrl4, sw4[15:0], regdst4, vec4},
               {q[0].alu, q[0].control, q[0].sw[15:0], q[0].regdst, q[0].vector});
    end else begin
      check_eq("nop_when_idle", control_out, 64'd1);
      check_eq("nop_when_idle4", ctrl4, 64'd1);
    end
    if (flushed) begin
      check_eq("zero_payload", {alu_out, sw_out, regdst_out, vector_ex_out}, 64'd0);
      flushed = 1'b0;
    end
    push = in_valid && exp_ir;
    pop  = exp_ov && out_ready;
    accepted = push;
    @(posedge clk);
    if (out_ready && !exp_ov) begin
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 1'b1;
      if (cnt4_m != 4'hF) cnt4_m = cnt4_m + 1'b1;
    end
    if (flush) begin
      q.delete();
      flushed = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(cur);
    end
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0);
    cnt_m    = '0;
    cnt4_m   = '0;
    flushed  = 1'b1;
    accepted = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values, then five idle cycles counted as bubbles.
    idle(5);
    check_eq("bubble_after_reset", bubble_cnt, 64'd5);

    // Back-to-back stream.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i);
      step();
    end
    idle(3);

    // Stall with a second beat offered.
    drive(1'b1, 32'hA);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'hB);
    for (int i = 0; i < 3; i++) begin
      step();
      if (accepted) in_valid = 1'b0;
    end
    check_eq("alu_hold_stall", alu_out, 64'hA);
    check_eq("in_ready_stall", in_ready, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4 && in_valid; i++) begin
      step();
      if (accepted) in_valid = 1'b0;
    end
    idle(3);

    // Flush while stalled with a fresh beat offered.
    drive(1'b1, 32'h21);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h22);
    step();
    if (accepted) in_valid = 1'b0;
    step();
    drive(1'b1, 32'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    check_eq("flush_alu_zero", alu_out, 64'd0);
    idle(3);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 32'h31);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h32);
    step();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 64'd0);
    check_eq("rst_control", control_out, 64'd1);
    check_eq("rst_payload", {alu_out, sw_out, regdst_out, vector_ex_out}, 64'd0);
    check_eq("rst_bubble", bubble_cnt, 64'd0);
    check_eq("rst_in_ready", in_ready, 64'd1);
    q.delete();
    cnt_m  = '0;
    cnt4_m = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h55);
    step();
    check_eq("post_reset_accept", accepted, 64'd1);
    drive(1'b0, 32'h0);
    step();
    check_eq("post_reset_alu", alu_out, 64'h55);

    // Long idle: the 4-bit counter must saturate.
    idle(20);
    check_eq("bubble4_saturated", bubble4, 64'hF);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 2) != 0), $urandom);
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0;

    // Drain whatever is left, bounded.
    idle(6);
    check_eq("drained", q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
